// File: rtl/sprite_loader.sv
// Streams a sprite (width byte, height byte, then RGB triples) into sprite RAM.
// One RAM write per pixel; header is validated against the RAM capacity first.
module sprite_loader #(
    parameter int          MAX_PIXELS = 1440,
    parameter logic [18:0] BASE_ADDR  = 19'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [18:0] write_address,
    output logic [23:0] data_In,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] HDR_W  = 4'd1;
    localparam logic [3:0] HDR_H  = 4'd2;
    localparam logic [3:0] CHECK  = 4'd3;
    localparam logic [3:0] PIX_R  = 4'd4;
    localparam logic [3:0] PIX_G  = 4'd5;
    localparam logic [3:0] PIX_B  = 4'd6;
    localparam logic [3:0] WRITE  = 4'd7;
    localparam logic [3:0] FINISH = 4'd8;

    localparam logic [15:0] MAX_TOTAL = 16'(MAX_PIXELS);

    logic [3:0]  state;
    logic [7:0]  width, height, red, green;
    logic [15:0] total, index, product;
    logic        hdr_bad, xfer;

    assign product = {8'd0, width} * {8'd0, height};
    assign hdr_bad = (width == 8'd0) || (height == 8'd0) || (product > MAX_TOTAL);

    always_comb begin
        rx_ready = (state == HDR_W) || (state == HDR_H) || (state == PIX_R) ||
                   (state == PIX_G) || (state == PIX_B);
        busy     = (state != IDLE);
        we       = (state == WRITE);
        done     = (state == FINISH);
        error    = (state == CHECK) && hdr_bad;
    end

    assign xfer = rx_valid & rx_ready;

    // Address and pixel are registered on the blue byte so they stay stable
    // through WRITE and hold afterwards while the index moves on.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= IDLE;
            width         <= 8'd0;
            height        <= 8'd0;
            red           <= 8'd0;
            green         <= 8'd0;
            total         <= 16'd0;
            index         <= 16'd0;
            write_address <= 19'd0;
            data_In       <= 24'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    index <= 16'd0;
                    state <= HDR_W;
                end
                HDR_W: if (xfer) begin
                    width <= rx_data;
                    state <= HDR_H;
                end
                HDR_H: if (xfer) begin
                    height <= rx_data;
                    state  <= CHECK;
                end
                CHECK: begin
                    total <= product;
                    state <= hdr_bad ? IDLE : PIX_R;
                end
                PIX_R: if (xfer) begin
                    red   <= rx_data;
                    state <= PIX_G;
                end
                PIX_G: if (xfer) begin
                    green <= rx_data;
                    state <= PIX_B;
                end
                PIX_B: if (xfer) begin
                    data_In       <= {red, green, rx_data};
                    write_address <= BASE_ADDR + {3'd0, index};
                    state         <= WRITE;
                end
                WRITE: begin
                    index <= index + 16'd1;
                    state <= (index == total - 16'd1) ? FINISH : PIX_R;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_loader.sv
// Randomized bench for sprite_loader: a queue-based model predicts every RAM
// write from the byte stream; outputs are sampled on the falling edge.
module tb_sprite_loader;
    localparam int MAXP = 1440;

    typedef logic [7:0] bq_t [$];

    logic        Clk = 1'b0;
    logic        Reset, start, rx_valid, rx_ready, we, busy, done, error;
    logic [7:0]  rx_data;
    logic [18:0] write_address;
    logic [23:0] data_In;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [18:0] last_addr = '0;
    logic [23:0] last_data = '0;
    logic        exp_busy  = 1'b0;

    always #5 Clk = ~Clk;

    sprite_loader #(.MAX_PIXELS(MAXP), .BASE_ADDR(19'd0)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .write_address(write_address),
        .data_In(data_In), .we(we), .busy(busy), .done(done), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // gap_mode: 0 valid always, 1 toggle, 2 random. reset_after: bytes consumed
    // before Reset is pulled low (-1 = never).
    task automatic run_load(input bq_t b, input int gap_mode, input int reset_after,
                            input bit start_glitch, input bit chk_time);
        logic [18:0] ea[$];
        logic [23:0] ed[$];
        int  w, h, tot, npix, budget;
        bit  exp_err;
        int  ptr = 0, c0 = -1, ch = -1, dn = 0, er = 0, post = 0;
        bit  glitched = 0, rst_now = 0, g;

        w       = (b.size() > 0) ? int'(b[0]) : 0;
        h       = (b.size() > 1) ? int'(b[1]) : 0;
        tot     = w * h;
        exp_err = (w == 0) || (h == 0) || (tot > MAXP);
        npix    = exp_err ? 0 : tot;
        if (reset_after >= 0 && (reset_after - 2) / 3 < npix) npix = (reset_after - 2) / 3;
        for (int i = 0; i < npix; i++) begin
            ea.push_back(19'(i));
            ed.push_back({b[2+3*i], b[3+3*i], b[4+3*i]});
        end
        budget = 8 * b.size() + 40;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge Clk);
            if (rst_now) begin
                check("rst_ctl", {27'd0, rx_ready, we, busy, done, error}, 0);
                check("rst_addr", write_address, 0);
                check("rst_data", data_In, 0);
                Reset = 1'b1;
                exp_busy = 1'b0;
                last_addr = '0;
                last_data = '0;
                break;
            end
            check("excl", $onehot0({we, done, error}), 1);
            check("busy", busy, exp_busy);
            if (we | done | error) check("rdy_off", rx_ready, 0);
            if (we) begin
                if (ea.size() == 0) begin
                    check("extra_we", 1, 0);
                    last_addr = write_address;
                    last_data = data_In;
                end else begin
                    last_addr = ea.pop_front();
                    last_data = ed.pop_front();
                    check("waddr", write_address, last_addr);
                    check("wdata", data_In, last_data);
                end
            end else begin
                check("hold_a", write_address, last_addr);
                check("hold_d", data_In, last_data);
            end
            if (done) begin
                dn++;
                if (chk_time) check("latency", cyc - c0, 3 + 4 * tot);
                exp_busy = 1'b0;
            end
            if (error) begin
                er++;
                check("err_lat", cyc - ch, 1);
                exp_busy = 1'b0;
            end
            if (post > 0) begin
                post--;
                if (post == 0) break;
            end
            if (done | error) post = 3;

            start = 1'b0;
            if (cyc == 0) begin
                start = 1'b1;
                exp_busy = 1'b1;
            end
            if (start_glitch && !glitched && rx_ready && ptr == 5) begin
                start = 1'b1;
                glitched = 1;
            end
            if (reset_after >= 0 && ptr == reset_after) begin
                Reset = 1'b0;
                rx_valid = 1'b0;
                rst_now = 1;
            end else begin
                case (gap_mode)
                    0: g = 1'b1;
                    1: g = (cyc % 2) == 0;
                    default: g = 1'($urandom_range(0, 1));
                endcase
                rx_valid = g && (ptr < b.size());
                rx_data  = (ptr < b.size()) ? b[ptr] : 8'h00;
                if (rx_valid && rx_ready) begin
                    ptr++;
                    if (ptr == 1) c0 = cyc;
                    if (ptr == 2) ch = cyc;
                end
            end
        end
        start = 1'b0;
        rx_valid = 1'b0;
        check("left_we", ea.size(), 0);
        check("done_cnt", dn, (exp_err || reset_after >= 0) ? 0 : 1);
        check("err_cnt", er, exp_err ? 1 : 0);
    endtask

    function automatic bq_t mk_stream(input int w, input int h);
        bq_t s;
        s.push_back(8'(w));
        s.push_back(8'(h));
        if (w * h <= MAXP)
            for (int i = 0; i < 3 * w * h; i++) s.push_back(8'($urandom));
        return s;
    endfunction

    initial begin
        bq_t s;
        Reset = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge Clk);
        check("init_ctl", {27'd0, rx_ready, we, busy, done, error}, 0);
        check("init_addr", write_address, 0);
        check("init_data", data_In, 0);
        Reset = 1'b1;

        s = {8'h02, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        run_load(s, 0, -1, 0, 1);
        s = {8'h00, 8'h05};
        run_load(s, 0, -1, 0, 0);
        s = {8'h25, 8'h28};
        run_load(s, 0, -1, 0, 0);
        s = {8'h05, 8'h00};
        run_load(s, 2, -1, 0, 0);
        run_load(mk_stream(36, 40), 0, -1, 0, 1);
        run_load(mk_stream(1, 1), 1, -1, 0, 0);
        run_load(mk_stream(3, 2), 0, 13, 0, 0);
        run_load(mk_stream(1, 1), 0, -1, 0, 1);
        run_load(mk_stream(2, 2), 0, -1, 1, 1);
        for (int k = 0; k < 8; k++)
            run_load(mk_stream($urandom_range(0, 5), $urandom_range(0, 5)), 2, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
